// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave. Signal names match the bus port list.
interface axil_reg_slave_if #(
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic                        S_AXI_AWVALID;
   logic                        S_AXI_AWREADY;
   logic [2:0]                  S_AXI_AWPROT;
   logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                        S_AXI_WVALID;
   logic                        S_AXI_WREADY;
   logic [1:0]                  S_AXI_BRESP;
   logic                        S_AXI_BVALID;
   logic                        S_AXI_BREADY;
   logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic                        S_AXI_ARVALID;
   logic                        S_AXI_ARREADY;
   logic [2:0]                  S_AXI_ARPROT;
   logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                  S_AXI_RRESP;
   logic                        S_AXI_RVALID;
   logic                        S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWPROT,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARPROT,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: CTRL, SCRATCH, STATUS, CYCLES and START registers
// with independent read and write channel FSMs.
module axil_reg_slave #(
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ADDR_WIDTH = 32
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESET,
   axil_reg_slave_if.slave           s_axi,
   output logic [AXI_DATA_WIDTH-1:0] ctrl_out,
   input  logic [AXI_DATA_WIDTH-1:0] status_in,
   output logic                      start_pulse
);
   localparam int unsigned DW = AXI_DATA_WIDTH;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = 10;

   localparam logic [IW-1:0] IDX_CTRL    = IW'(0);
   localparam logic [IW-1:0] IDX_SCRATCH = IW'(1);
   localparam logic [IW-1:0] IDX_STATUS  = IW'(2);
   localparam logic [IW-1:0] IDX_CYCLES  = IW'(3);
   localparam logic [IW-1:0] IDX_START   = IW'(4);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_RESP}         r_state_e;

   w_state_e        w_state_q, w_state_d;
   logic            awready_q, awready_d;
   logic            wready_q, wready_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [IW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [DW-1:0]   ctrl_q, ctrl_d;
   logic [DW-1:0]   scratch_q, scratch_d;
   logic [DW-1:0]   cycles_q, cycles_d;
   logic            start_pulse_q, start_pulse_d;

   r_state_e        r_state_q, r_state_d;
   logic            arready_q, arready_d;
   logic            rvalid_q, rvalid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [1:0]      rresp_q, rresp_d;

   logic            aw_hs, w_hs, b_hs, ar_hs;
   logic [IW-1:0]   waddr_cur, raddr_idx;
   logic [DW-1:0]   wdata_cur;
   logic [SW-1:0]   wstrb_cur;
   logic            unused_bits;

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int unsigned b = 0; b < SW; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
   assign w_hs  = s_axi.S_AXI_WVALID  & wready_q;
   assign b_hs  = bvalid_q & s_axi.S_AXI_BREADY;
   assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;

   // Same-cycle handshakes bypass the latches so the commit can happen one cycle later.
   assign waddr_cur = aw_hs ? s_axi.S_AXI_AWADDR[11:2] : waddr_q;
   assign wdata_cur = w_hs  ? s_axi.S_AXI_WDATA        : wdata_q;
   assign wstrb_cur = w_hs  ? s_axi.S_AXI_WSTRB        : wstrb_q;
   assign raddr_idx = s_axi.S_AXI_ARADDR[11:2];

   assign unused_bits = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR,
                          s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   // Write channel: collect AW and W in any order, commit, then hold B until accepted.
   always_comb begin
      w_state_d     = w_state_q;
      awready_d     = awready_q;
      wready_d      = wready_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      waddr_d       = waddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      ctrl_d        = ctrl_q;
      scratch_d     = scratch_q;
      start_pulse_d = 1'b0;
      cycles_d      = cycles_q + DW'(1);

      case (w_state_q)
         W_IDLE, W_WAIT: begin
            awready_d = ~(aw_done_q | aw_hs);
            wready_d  = ~(w_done_q | w_hs);
            if (aw_hs) begin
               waddr_d   = waddr_cur;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wdata_d  = wdata_cur;
               wstrb_d  = wstrb_cur;
               w_done_d = 1'b1;
            end
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = RESP_OKAY;
               w_state_d = W_RESP;
               case (waddr_cur)
                  IDX_CTRL:    ctrl_d        = apply_strb(ctrl_q, wdata_cur, wstrb_cur);
                  IDX_SCRATCH: scratch_d     = apply_strb(scratch_q, wdata_cur, wstrb_cur);
                  IDX_START:   start_pulse_d = wstrb_cur[0] & wdata_cur[0];
                  default:     bresp_d       = RESP_SLVERR;
               endcase
            end else if (aw_hs || w_hs) begin
               w_state_d = W_WAIT;
            end
         end
         W_RESP: begin
            if (b_hs) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: sample the register file on AR handshake, hold R until accepted.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      case (r_state_q)
         R_IDLE: begin
            arready_d = ~ar_hs;
            if (ar_hs) begin
               rvalid_d  = 1'b1;
               r_state_d = R_RESP;
               rresp_d   = RESP_OKAY;
               rdata_d   = '0;
               case (raddr_idx)
                  IDX_CTRL:    rdata_d = ctrl_q;
                  IDX_SCRATCH: rdata_d = scratch_q;
                  IDX_STATUS:  rdata_d = status_in;
                  IDX_CYCLES:  rdata_d = cycles_q;
                  IDX_START:   rdata_d = '0;
                  default:     rresp_d = RESP_SLVERR;
               endcase
            end
         end
         R_RESP: begin
            if (s_axi.S_AXI_RREADY) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         w_state_q     <= W_IDLE;
         awready_q     <= 1'b0;
         wready_q      <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= 2'b00;
         waddr_q       <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         ctrl_q        <= '0;
         scratch_q     <= '0;
         cycles_q      <= '0;
         start_pulse_q <= 1'b0;
         r_state_q     <= R_IDLE;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rdata_q       <= '0;
         rresp_q       <= 2'b00;
      end else begin
         w_state_q     <= w_state_d;
         awready_q     <= awready_d;
         wready_q      <= wready_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         ctrl_q        <= ctrl_d;
         scratch_q     <= scratch_d;
         cycles_q      <= cycles_d;
         start_pulse_q <= start_pulse_d;
         r_state_q     <= r_state_d;
         arready_q     <= arready_d;
         rvalid_q      <= rvalid_d;
         rdata_q       <= rdata_d;
         rresp_q       <= rresp_d;
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign ctrl_out            = ctrl_q;
   assign start_pulse         = start_pulse_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with B/R response scoreboards.
module tb_axil_reg_slave;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk;
   logic        areset;
   logic [31:0] ctrl_out;
   logic [31:0] status_in;
   logic        start_pulse;

   axil_reg_slave_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) axi ();

   axil_reg_slave #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (areset),
      .s_axi        (axi.slave),
      .ctrl_out     (ctrl_out),
      .status_in    (status_in),
      .start_pulse  (start_pulse)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulse_cnt = 0;
   logic [31:0] tb_cyc;
   logic [31:0] m_ctrl;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference free-running cycle count, same reset behaviour as the bus reset.
   always @(posedge clk) begin
      if (areset) tb_cyc <= '0;
      else        tb_cyc <= tb_cyc + 32'd1;
   end

   always @(negedge clk) if (start_pulse) pulse_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_hold,
                            input logic [1:0] exp_resp, input logic exp_pulse);
      bit aw_on, aw_done, w_done, aw_f, w_f;
      int cyc, lat;
      logic [1:0] e;
      bq.push_back(exp_resp);
      @(posedge clk); #1;
      axi.S_AXI_WDATA  = data;
      axi.S_AXI_WSTRB  = strb;
      axi.S_AXI_WVALID = 1'b1;
      aw_on = 1'b0; aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      if (w_lead == 0) begin
         axi.S_AXI_AWADDR = addr; axi.S_AXI_AWVALID = 1'b1; aw_on = 1'b1;
      end
      while (!(aw_done && w_done)) begin
         @(negedge clk);
         aw_f = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
         w_f  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
         @(posedge clk); #1;
         if (aw_f) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
         if (w_f)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
         cyc++;
         if (!aw_on && cyc >= w_lead) begin
            axi.S_AXI_AWADDR = addr; axi.S_AXI_AWVALID = 1'b1; aw_on = 1'b1;
         end
         if (cyc > 40 && !(aw_done && w_done)) begin
            check("write handshake timeout", 32'(aw_done && w_done), 32'd1);
            axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
            void'(bq.pop_back());
            return;
         end
      end
      @(negedge clk);
      check("bvalid cycle after last handshake", 32'(axi.S_AXI_BVALID), 32'd1);
      lat = 0;
      while (!axi.S_AXI_BVALID && lat < 20) begin @(negedge clk); lat++; end
      e = bq.pop_front();
      check("bresp", 32'(axi.S_AXI_BRESP), 32'(e));
      check("start_pulse with bvalid rise", 32'(start_pulse), 32'(exp_pulse));
      check("ctrl_out with bvalid rise", ctrl_out, m_ctrl);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         check("bvalid held", 32'(axi.S_AXI_BVALID), 32'd1);
         check("bresp held", 32'(axi.S_AXI_BRESP), 32'(e));
         check("awready low in resp", 32'(axi.S_AXI_AWREADY), 32'd0);
         check("wready low in resp", 32'(axi.S_AXI_WREADY), 32'd0);
      end
      @(posedge clk); #1 axi.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      check("awready low during b handshake", 32'(axi.S_AXI_AWREADY), 32'd0);
      check("start_pulse single cycle", 32'(start_pulse), 32'd0);
      @(posedge clk); #1 axi.S_AXI_BREADY = 1'b0;
      @(negedge clk);
      check("bvalid drop after b handshake", 32'(axi.S_AXI_BVALID), 32'd0);
      check("awready back after b", 32'(axi.S_AXI_AWREADY), 32'd1);
      check("wready back after b", 32'(axi.S_AXI_WREADY), 32'd1);
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input bit use_cyc);
      bit fire;
      int cyc, lat;
      logic [33:0] e;
      @(posedge clk); #1;
      axi.S_AXI_ARADDR  = addr;
      axi.S_AXI_ARVALID = 1'b1;
      fire = 1'b0; cyc = 0;
      while (!fire) begin
         @(negedge clk);
         fire = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
         if (fire) rq.push_back({exp_resp, use_cyc ? tb_cyc : exp_data});
         @(posedge clk); #1;
         if (fire) axi.S_AXI_ARVALID = 1'b0;
         cyc++;
         if (cyc > 40 && !fire) begin
            check("read handshake timeout", 32'(fire), 32'd1);
            axi.S_AXI_ARVALID = 1'b0;
            return;
         end
      end
      @(negedge clk);
      check("rvalid cycle after ar handshake", 32'(axi.S_AXI_RVALID), 32'd1);
      lat = 0;
      while (!axi.S_AXI_RVALID && lat < 20) begin @(negedge clk); lat++; end
      e = rq.pop_front();
      check("rdata", axi.S_AXI_RDATA, e[31:0]);
      check("rresp", 32'(axi.S_AXI_RRESP), 32'(e[33:32]));
      @(posedge clk); #1 axi.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1 axi.S_AXI_RREADY = 1'b0;
      @(negedge clk);
      check("rvalid drop after r handshake", 32'(axi.S_AXI_RVALID), 32'd0);
      check("arready back after r", 32'(axi.S_AXI_ARREADY), 32'd1);
   endtask

   initial begin
      int p0;
      int seen;
      areset = 1'b1;
      status_in = 32'hCAFE_F00D;
      m_ctrl = '0;
      axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_AWPROT = 3'b000;
      axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB   = '0;   axi.S_AXI_WVALID = 1'b0;
      axi.S_AXI_BREADY = 1'b0;
      axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_ARPROT = 3'b000;
      axi.S_AXI_RREADY = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset awready", 32'(axi.S_AXI_AWREADY), 32'd0);
      check("reset wready", 32'(axi.S_AXI_WREADY), 32'd0);
      check("reset arready", 32'(axi.S_AXI_ARREADY), 32'd0);
      check("reset bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
      check("reset rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
      check("reset bresp", 32'(axi.S_AXI_BRESP), 32'd0);
      check("reset rresp", 32'(axi.S_AXI_RRESP), 32'd0);
      check("reset rdata", axi.S_AXI_RDATA, 32'd0);
      check("reset start_pulse", 32'(start_pulse), 32'd0);
      check("reset ctrl_out", ctrl_out, 32'd0);
      @(posedge clk); #1 areset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("awready after reset", 32'(axi.S_AXI_AWREADY), 32'd1);
      check("wready after reset", 32'(axi.S_AXI_WREADY), 32'd1);
      check("arready after reset", 32'(axi.S_AXI_ARREADY), 32'd1);

      // AW and W together to SCRATCH, read back
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY, 1'b0);
      axi_read(32'h04, 32'hDEAD_BEEF, OKAY, 1'b0);

      // W leads AW by three cycles, partial strobe on CTRL
      m_ctrl = 32'h0000_5678;
      axi_write(32'h00, 32'h1234_5678, 4'h3, 3, 0, OKAY, 1'b0);
      check("ctrl_out after strobed write", ctrl_out, 32'h0000_5678);
      axi_read(32'h00, 32'h0000_5678, OKAY, 1'b0);

      // Back-pressured B, single-byte strobe, aliased read address
      axi_write(32'h04, 32'h0000_00A5, 4'h1, 1, 5, OKAY, 1'b0);
      axi_read(32'h0000_1007, 32'hDEAD_BEA5, OKAY, 1'b0);

      // Unmapped and read-only offsets
      axi_read(32'h20, 32'h0, SLVERR, 1'b0);
      axi_write(32'h0C, 32'hFFFF_0000, 4'hF, 0, 0, SLVERR, 1'b0);
      axi_read(32'h0C, 32'h0, OKAY, 1'b1);
      axi_write(32'h08, 32'h1111_1111, 4'hF, 0, 0, SLVERR, 1'b0);
      axi_read(32'h08, 32'hCAFE_F00D, OKAY, 1'b0);
      axi_write(32'h40, 32'h5555_5555, 4'hF, 2, 0, SLVERR, 1'b0);
      axi_read(32'h04, 32'hDEAD_BEA5, OKAY, 1'b0);

      // START strobe behaviour
      p0 = pulse_cnt;
      axi_write(32'h10, 32'h1, 4'h1, 0, 0, OKAY, 1'b1);
      check("one pulse per start write", 32'(pulse_cnt - p0), 32'd1);
      axi_read(32'h10, 32'h0, OKAY, 1'b0);
      p0 = pulse_cnt;
      axi_write(32'h10, 32'h3, 4'hF, 0, 0, OKAY, 1'b1);
      axi_write(32'h10, 32'h1, 4'hF, 0, 0, OKAY, 1'b1);
      check("back-to-back start pulses", 32'(pulse_cnt - p0), 32'd2);
      p0 = pulse_cnt;
      axi_write(32'h10, 32'h1, 4'hE, 0, 0, OKAY, 1'b0);
      axi_write(32'h10, 32'h0, 4'hF, 0, 0, OKAY, 1'b0);
      check("no pulse without strobe or bit0", 32'(pulse_cnt - p0), 32'd0);

      // Reset between AR handshake and RREADY
      @(posedge clk); #1;
      axi.S_AXI_ARADDR = 32'h00; axi.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      check("arready before aborted read", 32'(axi.S_AXI_ARREADY), 32'd1);
      @(posedge clk); #1 axi.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      check("rvalid before reset", 32'(axi.S_AXI_RVALID), 32'd1);
      @(posedge clk); #1 areset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rvalid during reset", 32'(axi.S_AXI_RVALID), 32'd0);
      check("rdata during reset", axi.S_AXI_RDATA, 32'd0);
      check("ctrl_out after reset", ctrl_out, 32'd0);
      @(posedge clk); #1;
      areset = 1'b0;
      axi.S_AXI_RREADY = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (axi.S_AXI_RVALID) seen++;
      end
      check("no r beat after reset", 32'(seen), 32'd0);
      @(posedge clk); #1 axi.S_AXI_RREADY = 1'b0;
      m_ctrl = '0;
      axi_read(32'h00, 32'h0, OKAY, 1'b0);
      axi_read(32'h04, 32'h0, OKAY, 1'b0);

      check("b scoreboard drained", 32'(bq.size()), 32'd0);
      check("r scoreboard drained", 32'(rq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL run on one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; only the value 32 is supported.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width; must be at least 12.
REQ-004 SHALL have port S_AXI_ACLK, input, 1, the single clock.
REQ-005 SHALL have port S_AXI_ARESET, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports S_AXI_AWADDR (input, AXI_ADDR_WIDTH), S_AXI_AWVALID (input, 1), S_AXI_AWREADY (output, 1) and S_AXI_AWPROT (input, 3, ignored), forming the write-address channel.
REQ-007 SHALL have ports S_AXI_WDATA (input, 32), S_AXI_WSTRB (input, 4), S_AXI_WVALID (input, 1) and S_AXI_WREADY (output, 1), forming the write-data channel.
REQ-008 SHALL have ports S_AXI_BRESP (output, 2), S_AXI_BVALID (output, 1) and S_AXI_BREADY (input, 1), forming the write-response channel.
REQ-009 SHALL have ports S_AXI_ARADDR (input, AXI_ADDR_WIDTH), S_AXI_ARVALID (input, 1), S_AXI_ARREADY (output, 1) and S_AXI_ARPROT (input, 3, ignored), forming the read-address channel.
REQ-010 SHALL have ports S_AXI_RDATA (output, 32), S_AXI_RRESP (output, 2), S_AXI_RVALID (output, 1) and S_AXI_RREADY (input, 1), forming the read-data channel.
REQ-011 SHALL have ports ctrl_out (output, 32, CTRL register value), status_in (input, 32, sampled for STATUS) and start_pulse (output, 1, one-cycle strobe).

Function
REQ-012 SHALL decode only address bits [11:2] and ignore bits [1:0] and bits above 11.
REQ-013 SHALL implement this register map: 0x00 CTRL (R/W); 0x04 SCRATCH (R/W); 0x08 STATUS (RO, returns status_in); 0x0C CYCLES (RO, 32-bit free-running counter); 0x10 START (WO; writing with bit0=1 pulses start_pulse; reads return 0).
REQ-014 SHALL apply WSTRB per byte to CTRL and SCRATCH; START SHALL act only when WSTRB[0]=1 and WDATA[0]=1.
REQ-015 SHALL treat all other offsets as unmapped: writes have no effect and return BRESP=2'b10 (SLVERR); reads return RDATA=0 and RRESP=2'b10.
REQ-016 SHALL ignore writes to STATUS and CYCLES and return SLVERR for them; every other mapped access SHALL return OKAY (2'b00).
REQ-017 SHALL use a write FSM with states W_IDLE, W_WAIT and W_RESP.
REQ-018 In W_IDLE, SHALL drive AWREADY=1 and WREADY=1.
REQ-019 SHALL drop each ready the cycle after its own handshake, latch the address or data, and enter W_WAIT until both handshakes are done; AW and W may arrive in either order or in the same cycle.
REQ-020 SHALL commit the register update and assert BVALID on the cycle after the later of the AW and W handshakes, entering W_RESP.
REQ-021 SHALL hold BVALID and BRESP stable until BREADY=1; on the B handshake it SHALL go to W_IDLE and re-assert both readies on the next cycle.
REQ-022 SHALL use a read FSM with states R_IDLE and R_RESP; ARREADY=1 only in R_IDLE.
REQ-023 SHALL register RDATA and RRESP on the AR handshake (value before any same-cycle write commit) and assert RVALID on the next cycle.
REQ-024 SHALL hold RVALID, RDATA and RRESP stable until RREADY=1, then return to R_IDLE.
REQ-025 SHALL run the read and write FSMs independently; concurrent read and write, including to the same register, are allowed.
REQ-026 SHALL increment CYCLES every clock and wrap from 0xFFFFFFFF to 0x00000000.
REQ-027 SHALL assert start_pulse for exactly one cycle, coincident with the BVALID rise of a qualifying START write.
REQ-028 SHALL ensure back-to-back START writes give one pulse per write, never merged.
REQ-029 SHALL drive ctrl_out continuously from the CTRL register; an update is visible the cycle BVALID rises.

Reset
REQ-030 While S_AXI_ARESET=1, SHALL hold AWREADY, WREADY, ARREADY, BVALID, RVALID and start_pulse at 0; BRESP, RRESP and RDATA at 0; CTRL, SCRATCH and CYCLES at 0; both FSMs in IDLE.
REQ-031 SHALL raise the readies on the first cycle after reset deasserts.
REQ-032 A reset mid-transaction SHALL abandon it with no B or R response issued and no register update.

Verification
REQ-033 Bench SHALL cover: AW and W in the same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 0xF -> BVALID one cycle later, BRESP=0; a read of 0x04 returns 0xDEADBEEF with RRESP=0.
REQ-034 Bench SHALL cover: W three cycles before AW, addr 0x00, data 0x12345678, WSTRB 0x3 (CTRL previously 0) -> ctrl_out=0x00005678, BRESP=0.
REQ-035 Bench SHALL cover: BREADY held low for 5 cycles -> BVALID and BRESP stable for 5 cycles; AWREADY and WREADY stay 0 until one cycle after the B handshake.
REQ-036 Bench SHALL cover: a read of 0x20 and a write to 0x0C -> RRESP=2'b10 with RDATA=0; BRESP=2'b10 with CYCLES unaffected.
REQ-037 Bench SHALL cover: a write of 0x1 to 0x10 -> start_pulse high for exactly 1 cycle; a read of 0x10 returns 0.
REQ-038 Bench SHALL cover: reset asserted after the AR handshake but before RREADY -> RVALID=0 during reset and no R beat afterwards; CTRL=0 after reset.
